exception_sequencer: RTL
========================

# exception_sequencer

Multi-cycle exception handler sitting directly upstream of the memory-address select mux. On an invalid-opcode, overflow or divide-by-zero event it saves the faulting PC to EPC. It then drives the address-select code for the matching vector register (253/254/255) and waits for memory read data. Finally it loads PC with the zero-extended vector byte. The main control unit stalls while `exc_busy` is high.

## Interface

- `MEM_LATENCY`, default 2: cycles from address-select change to valid `mem_data`; legal range 1–7.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `exc_opcode`  in  1  invalid-opcode event (level, sampled in IDLE only).
- `exc_overflow`  in  1  ALU overflow event (level, sampled in IDLE only).
- `exc_divzero`  in  1  divide-by-zero event (level, sampled in IDLE only).
- `pc_in`  in  32  current PC value (already incremented by 4).
- `mem_data`  in  32  memory read data.
- `iord_sel`  out  3  address-select code to the memory-address mux: 000 = PC, 001 = reg253, 010 = reg254, 011 = reg255.
- `epc_write`  out  1  one-cycle EPC load strobe.
- `epc_value`  out  32  value for EPC, equal to `pc_in − 4`.
- `pc_write`  out  1  one-cycle PC load strobe.
- `pc_value`  out  32  new PC value, equal to `{24'b0, mem_data[7:0]}`.
- `exc_busy`  out  1  high in every state except IDLE.
- `exc_done`  out  1  one-cycle pulse when the sequence completes.
- `cause`  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 divzero.

## Operation

- States: IDLE, SAVE, FETCH, LOAD, DONE.
- **IDLE**
  - `iord_sel` = 000; all strobes low; `exc_busy` = 0.
  - If any exception input is high, latch `cause` and go to SAVE.
  - Priority when several inputs are high: opcode > overflow > divzero.
- **SAVE** (1 cycle)
  - `epc_write` = 1; `epc_value` = `pc_in − 4`, modulo 2^32 (`pc_in` = 0 gives 0xFFFFFFFC).
  - `iord_sel` already driven to the vector code for `cause`.
  - Go to FETCH; load the wait counter with `MEM_LATENCY − 1`.
- **FETCH**
  - Hold `iord_sel` at the vector code.
  - Decrement the counter each cycle.
  - When the counter is 0, go to LOAD.
- **LOAD** (1 cycle)
  - Hold `iord_sel`.
  - `pc_write` = 1; `pc_value` = zero-extended `mem_data[7:0]` sampled this cycle.
  - Go to DONE.
- **DONE** (1 cycle)
  - `exc_done` = 1; `iord_sel` = 000; `cause` is kept.
  - Go to IDLE.
- Vector code mapping: opcode → 001, overflow → 010, divzero → 011. Codes 100–111 are never driven.
- Exception inputs are ignored outside IDLE; no queuing. An input still high in IDLE after DONE starts a new sequence.
- `cause` changes only on a new capture or on reset.

## Timing

- Reset (synchronous) forces these values:
  - state = IDLE, `iord_sel` = 000, `cause` = 00;
  - `epc_write`, `pc_write`, `exc_busy`, `exc_done` = 0;
  - `epc_value` = 0, `pc_value` = 0.
- Reset mid-sequence: the next cycle is IDLE with no `pc_write` or `exc_done`. An EPC write already issued is not undone.
- Reset has priority over simultaneous exception inputs.
- Event sampled at edge N:
  - SAVE in cycle N+1;
  - FETCH for `MEM_LATENCY` cycles;
  - LOAD in cycle N+2+`MEM_LATENCY`;
  - DONE one cycle later.
- Total `exc_busy` high time is `MEM_LATENCY` + 3 cycles; 5 cycles at the default.
- All outputs are registered or decoded purely from registered state. `pc_value` is the only output combinational from `mem_data`, and is valid in LOAD only.
- `iord_sel` is stable from SAVE through LOAD, so the memory address never glitches during the fetch.

## Test plan

- **Reset values:** assert `reset` for 2 cycles with all exception inputs high → every output at its reset value, `iord_sel` = 000, `exc_busy` = 0.
- **Overflow, default latency:** `exc_overflow` pulse, `pc_in` = 0x00000040, `mem_data[7:0]` = 0x9C → `epc_write` with 0x0000003C; `iord_sel` = 010 for 4 cycles; `pc_write` with 0x0000009C; `exc_done`; `cause` = 10; `exc_busy` high 5 cycles.
- **Priority:** `exc_opcode`, `exc_overflow` and `exc_divzero` all high together → `cause` = 01, `iord_sel` = 001.
- **Events ignored while busy:** `exc_divzero` asserted during FETCH of an opcode sequence, then dropped → no second sequence, `cause` stays 01. Held through DONE instead → a second sequence starts with `iord_sel` = 011.
- **Reset mid-sequence:** `reset` asserted during FETCH → IDLE next cycle, `pc_write` never asserted, `iord_sel` = 000, `cause` = 00.
- **Latency sweep and wrap:** `MEM_LATENCY` = 1 and 7 → `pc_write` at cycles N+3 and N+9. `pc_in` = 0 → `epc_value` = 0xFFFFFFFC.

Source files
------------

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multi-cycle exception handler: save EPC, fetch vector byte, load PC
module exception_sequencer #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [2:0]  iord_sel,
  output logic        epc_write,
  output logic [31:0] epc_value,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic        exc_busy,
  output logic        exc_done,
  output logic [1:0]  cause
);

  typedef enum logic [2:0] {IDLE, SAVE, FETCH, LOAD, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] cnt;
  logic [1:0] new_cause;
  logic       any_exc;
  logic       unused_mem_bits;

  assign any_exc = exc_opcode | exc_overflow | exc_divzero;
  assign unused_mem_bits = ^mem_data[31:8];

  always_comb begin
    new_cause = 2'b00;
    if (exc_opcode)        new_cause = 2'b01;
    else if (exc_overflow) new_cause = 2'b10;
    else if (exc_divzero)  new_cause = 2'b11;
  end

  // Only output that is combinational on mem_data; zero outside LOAD.
  assign pc_value = (state == LOAD) ? {24'b0, mem_data[7:0]} : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      iord_sel  <= 3'b000;
      cause     <= 2'b00;
      epc_write <= 1'b0;
      epc_value <= 32'd0;
      pc_write  <= 1'b0;
      exc_busy  <= 1'b0;
      exc_done  <= 1'b0;
    end else begin
      epc_write <= 1'b0;
      pc_write  <= 1'b0;
      exc_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_exc) begin
            state     <= SAVE;
            cause     <= new_cause;
            // Vector code is the cause with a zero MSB: 001/010/011.
            iord_sel  <= {1'b0, new_cause};
            epc_write <= 1'b1;
            epc_value <= pc_in - 32'd4;
            exc_busy  <= 1'b1;
          end
        end
        SAVE: begin
          state <= FETCH;
          cnt   <= CNT_INIT;
        end
        FETCH: begin
          if (cnt == 3'd0) begin
            state    <= LOAD;
            pc_write <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        LOAD: begin
          state    <= DONE;
          iord_sel <= 3'b000;
          exc_done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          exc_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
